// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift-chain controller and its datapath.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Width of a counter that must hold every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_piso_core.sv
// Loadable parallel-in/serial-out register. bit_out is the bit that leaves on this edge,
// taken from din when loading so the first bit can go out in the same cycle as the load.
module shift_piso_core
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit_out
);

  logic [WIDTH-1:0] sreg_q, sreg_d, src;

  always_comb begin
    src = load ? din : sreg_q;
    if (shift) begin
      sreg_d = LSB_FIRST ? {1'b0, src[WIDTH-1:1]} : {src[WIDTH-2:0], 1'b0};
    end else begin
      sreg_d = src;
    end
  end

  assign bit_out = LSB_FIRST ? src[0] : src[WIDTH-1];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Valid/ready word accept -> registered serial sdo/sdo_en stream with hold, gap and done pulse.
// Define SHIFT_SEQ_PARITY_EN to append an even-parity bit to every frame.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             hold,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             done
);

`ifdef SHIFT_SEQ_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int              CW       = cnt_width(FRAME);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME);
  localparam logic [3:0]      GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // bits already driven onto sdo for this word
  logic [3:0]    gap_q, gap_d;
  logic          sdo_q, sdo_d;
  logic          sdo_en_q, sdo_en_d;
  logic          done_q, done_d;
  logic          load, shift, core_bit, emit_bit;
`ifdef SHIFT_SEQ_PARITY_EN
  logic          par_q, par_d;
`endif

  shift_piso_core #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (shift),
    .din    (in_data),
    .bit_out(core_bit)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sdo_d    = 1'b0;
    sdo_en_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    emit_bit = core_bit;
`ifdef SHIFT_SEQ_PARITY_EN
    par_d    = par_q;
    if (cnt_q == CW'(WIDTH)) emit_bit = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
          cnt_d   = '0;
`ifdef SHIFT_SEQ_PARITY_EN
          par_d   = ^in_data;
`endif
          if (!hold) begin
            shift    = 1'b1;
            sdo_d    = core_bit;
            sdo_en_d = 1'b1;
            cnt_d    = CW'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          gap_d  = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (hold) begin
          sdo_d = sdo_q;
        end else begin
          shift    = 1'b1;
          sdo_d    = emit_bit;
          sdo_en_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      sdo_q    <= 1'b0;
      sdo_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sdo_q    <= sdo_d;
      sdo_en_q <= sdo_en_d;
      done_q   <= done_d;
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign sdo      = sdo_q;
  assign sdo_en   = sdo_en_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: LSB/MSB order, hold, back-to-back, gap, reset abort, parity.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F = 4 + PAR;

  logic       clk;
  logic       rst;
  logic [2:0] in_valid;
  logic [2:0] hold;
  logic [3:0] in_data [3];
  wire  [2:0] in_ready, sdo, sdo_en, busy, done;

  int checks = 0;
  int errors = 0;

  // u0: LSB first, no gap; u1: MSB first; u2: LSB first with a 3-cycle gap.
  shift_seq_ctrl #(.WIDTH(4), .GAP_CYCLES(0), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .hold(hold[0]), .sdo(sdo[0]), .sdo_en(sdo_en[0]), .busy(busy[0]), .done(done[0]));
  shift_seq_ctrl #(.WIDTH(4), .GAP_CYCLES(0), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .hold(hold[1]), .sdo(sdo[1]), .sdo_en(sdo_en[1]), .busy(busy[1]), .done(done[1]));
  shift_seq_ctrl #(.WIDTH(4), .GAP_CYCLES(3), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .hold(hold[2]), .sdo(sdo[2]), .sdo_en(sdo_en[2]), .busy(busy[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on instance u and records the serial frame until done (bounded).
  // bits[i] is the i-th emitted bit; stall_sdo collects sdo during hold stalls.
  task automatic run_word(input int u, input logic [3:0] w, input int hold_after,
                          input int hold_len, output logic [7:0] bits, output int nbits,
                          output int done_at, output int ready_low, output int stall_cyc,
                          output logic [3:0] stall_sdo);
    int  hold_left;
    bit  started;
    bits = '0; nbits = 0; done_at = 0; ready_low = 0; stall_cyc = 0; stall_sdo = '0;
    hold_left = 0; started = 1'b0;
    in_valid[u] = 1'b1;
    in_data[u]  = w;
    tick();
    in_valid[u] = 1'b0;
    in_data[u]  = ~w;
    for (int k = 1; k <= 40; k++) begin
      if (done[u]) begin
        done_at = k;
        break;
      end
      if (!in_ready[u]) ready_low++;
      if (sdo_en[u]) begin
        bits[nbits] = sdo[u];
        nbits++;
      end else if (!in_ready[u]) begin
        stall_sdo[stall_cyc] = sdo[u];
        stall_cyc++;
      end
      if (hold_len > 0 && !started && nbits == hold_after) begin
        started     = 1'b1;
        hold[u]     = 1'b1;
        hold_left   = hold_len;
      end
      tick();
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold[u] = 1'b0;
      end
    end
    hold[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0;
    hold = '0;
    for (int i = 0; i < 3; i++) in_data[i] = 4'h0;
    tick();
    tick();
    checks++;
    if (in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 111", in_ready);
    end
    checks++;
    if ({sdo, sdo_en, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got sdo=%b en=%b busy=%b done=%b expected all 0",
               sdo, sdo_en, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits; int n, d, rl, sc; logic [3:0] ss;
    run_word(0, 4'b1011, 0, 0, bits, n, d, rl, sc, ss);
    checks++;
    if (bits !== ((PAR != 0) ? 8'h1B : 8'h0B)) begin
      errors++;
      $display("FAIL lsb_bits: got %h expected %h", bits, (PAR != 0) ? 8'h1B : 8'h0B);
    end
    checks++;
    if (n !== F) begin errors++; $display("FAIL lsb_nbits: got %0d expected %0d", n, F); end
    checks++;
    if (d !== F + 1) begin errors++; $display("FAIL lsb_done_at: got %0d expected %0d", d, F + 1); end
    checks++;
    if (rl !== F) begin errors++; $display("FAIL lsb_ready_low: got %0d expected %0d", rl, F); end
  endtask

  task automatic test_msb_first();
    logic [7:0] bits; int n, d, rl, sc; logic [3:0] ss;
    run_word(1, 4'b1000, 0, 0, bits, n, d, rl, sc, ss);
    checks++;
    if (bits !== ((PAR != 0) ? 8'h11 : 8'h01)) begin
      errors++;
      $display("FAIL msb_bits: got %h expected %h", bits, (PAR != 0) ? 8'h11 : 8'h01);
    end
    checks++;
    if (d !== F + 1) begin errors++; $display("FAIL msb_done_at: got %0d expected %0d", d, F + 1); end
  endtask

  task automatic test_hold();
    logic [7:0] bits; int n, d, rl, sc; logic [3:0] ss;
    run_word(0, 4'b0110, 2, 2, bits, n, d, rl, sc, ss);
    checks++;
    if (bits !== 8'h06) begin errors++; $display("FAIL hold_bits: got %h expected 06", bits); end
    checks++;
    if (sc !== 2) begin errors++; $display("FAIL hold_stall_cycles: got %0d expected 2", sc); end
    checks++;
    if (ss[1:0] !== 2'b11) begin errors++; $display("FAIL hold_sdo_held: got %b expected 11", ss[1:0]); end
    checks++;
    if (d !== F + 3) begin errors++; $display("FAIL hold_done_at: got %0d expected %0d", d, F + 3); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq; int n; logic d1, r1, d2;
    seq = '0; n = 0; d1 = 1'b0; r1 = 1'b0; d2 = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hA;
    tick();
    in_data[0]  = 4'h5;
    for (int k = 1; k <= 2 * F + 2; k++) begin
      if (sdo_en[0]) begin seq[n] = sdo[0]; n++; end
      if (k == F + 1) begin d1 = done[0]; r1 = in_ready[0]; end
      if (k == 2 * F + 2) d2 = done[0];
      tick();
      if (k == F + 1) in_valid[0] = 1'b0;
    end
    checks++;
    if (seq !== ((PAR != 0) ? 16'h00AA : 16'h005A)) begin
      errors++;
      $display("FAIL b2b_bits: got %h expected %h", seq, (PAR != 0) ? 16'h00AA : 16'h005A);
    end
    checks++;
    if (n !== 2 * F) begin errors++; $display("FAIL b2b_nbits: got %0d expected %0d", n, 2 * F); end
    checks++;
    if ({d1, r1} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_done_ready: got done=%b ready=%b expected 1 1", d1, r1);
    end
    checks++;
    if (d2 !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", d2); end
  endtask

  task automatic test_gap();
    int gapc; logic d1, r3, r4, e5, s5, d2;
    gapc = 0; d1 = 1'b0; r3 = 1'b1; r4 = 1'b0; e5 = 1'b0; s5 = 1'b0; d2 = 1'b0;
    in_valid[2] = 1'b1;
    in_data[2]  = 4'hA;
    tick();
    in_data[2]  = 4'h5;
    for (int k = 1; k <= 2 * F + 5; k++) begin
      if (k >= F + 1 && k <= F + 4 && busy[2] && !sdo_en[2]) gapc++;
      if (k == F + 1) d1 = done[2];
      if (k == F + 3) r3 = in_ready[2];
      if (k == F + 4) r4 = in_ready[2];
      if (k == F + 5) begin e5 = sdo_en[2]; s5 = sdo[2]; end
      if (k == 2 * F + 5) d2 = done[2];
      tick();
      if (k == F + 4) in_valid[2] = 1'b0;
    end
    checks++;
    if (gapc !== 3) begin errors++; $display("FAIL gap_busy_cycles: got %0d expected 3", gapc); end
    checks++;
    if (d1 !== 1'b1) begin errors++; $display("FAIL gap_done: got %b expected 1", d1); end
    checks++;
    if ({r3, r4} !== 2'b01) begin
      errors++;
      $display("FAIL gap_ready: got %b%b expected 01", r3, r4);
    end
    checks++;
    if ({e5, s5} !== 2'b11) begin
      errors++;
      $display("FAIL gap_second_first_bit: got en=%b sdo=%b expected 1 1", e5, s5);
    end
    checks++;
    if (d2 !== 1'b1) begin errors++; $display("FAIL gap_second_done: got %b expected 1", d2); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] bits; int n, d, rl, sc, dcount; logic [3:0] ss;
    dcount = 0;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hF;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    checks++;
    if ({sdo_en[0], sdo[0]} !== 2'b11) begin
      errors++;
      $display("FAIL abort_third_bit: got en=%b sdo=%b expected 1 1", sdo_en[0], sdo[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready[0], sdo[0], sdo_en[0], busy[0], done[0]} !== 5'b10000) begin
      errors++;
      $display("FAIL abort_outputs: got ready=%b sdo=%b en=%b busy=%b done=%b expected 1 0 0 0 0",
               in_ready[0], sdo[0], sdo_en[0], busy[0], done[0]);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done[0]) dcount++;
      tick();
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcount); end
    run_word(0, 4'b1001, 0, 0, bits, n, d, rl, sc, ss);
    checks++;
    if (bits !== 8'h09) begin errors++; $display("FAIL abort_next_bits: got %h expected 09", bits); end
    checks++;
    if (d !== F + 1) begin errors++; $display("FAIL abort_next_done: got %0d expected %0d", d, F + 1); end
  endtask

`ifdef SHIFT_SEQ_PARITY_EN
  task automatic test_parity();
    logic [7:0] bits; int n, d, rl, sc; logic [3:0] ss;
    run_word(0, 4'b0111, 0, 0, bits, n, d, rl, sc, ss);
    checks++;
    if (bits !== 8'h17) begin errors++; $display("FAIL parity_bits: got %h expected 17", bits); end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL parity_nbits: got %0d expected 5", n); end
    checks++;
    if (d !== 6) begin errors++; $display("FAIL parity_done_at: got %0d expected 6", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_hold();
    test_back_to_back();
    test_gap();
    test_reset_abort();
`ifdef SHIFT_SEQ_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Controller that sequences a serial shift datapath.
- Accepts a parallel word on a valid/ready handshake and drives a serial data/enable pair, one bit per clock, into a downstream serial-in shift chain.
- Provides stall (hold), a programmable inter-word gap, and a done pulse so upstream logic can schedule back-to-back transfers.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- GAP_CYCLES, 0, idle cycles inserted after each word before the next accept (0..15).
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  parallel word valid.
- in_data  input  WIDTH  parallel word.
- in_ready  output  1  controller can accept a word.
- hold  input  1  stall serial output while high.
- sdo  output  1  serial data to the shift chain.
- sdo_en  output  1  sdo carries a valid bit this cycle (shift enable for the chain).
- busy  output  1  transfer in progress (SHIFT or GAP).
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Clocking and reset: one clock; rst is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, sdo=0, sdo_en=0, busy=0, done=0, bit counter=0, shift register=0.
- Reset mid-transfer aborts immediately. The partial word is discarded, no done pulse is issued, and the controller comes out of reset in IDLE.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - An accept occurs on a rising edge with in_valid&in_ready.
  - On accept: in_data is latched into the internal shift register, counter=0, next state=SHIFT.
  - in_data is ignored when no accept occurs.
- SHIFT:
  - in_ready=0, busy=1.
  - With hold=0: sdo_en=1 and sdo = current bit (LSB or MSB per LSB_FIRST). The register shifts and the counter increments each cycle.
  - With hold=1: sdo_en=0, sdo holds its last value, and the counter and register freeze.
  - A hold asserted on the accept edge takes effect in the first SHIFT cycle.
- Last bit (counter=WIDTH-1 with hold=0):
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
  - done=1 for exactly one cycle, the cycle after the last bit.
- GAP:
  - busy=1, sdo_en=0, sdo=0.
  - Lasts exactly GAP_CYCLES cycles and ignores hold, then returns to IDLE.
- Latency: accept at edge T gives first bit at cycle T+1 and last bit at T+WIDTH (with no hold).
- Throughput: with GAP_CYCLES=0, a word is accepted every WIDTH+1 cycles. in_ready rises in the same cycle as done.
- sdo is registered and returns to 0 whenever it is not in SHIFT. Exception: it holds its value under hold.
- Counter width is clog2(WIDTH+1); it never wraps within a word.

Optional Feature:
- Macro: SHIFT_SEQ_PARITY_EN.
- With the macro defined:
  - After the WIDTH data bits, one extra SHIFT cycle emits even parity (XOR of the latched word) with sdo_en=1.
  - hold stalls the parity bit the same way it stalls data bits.
  - done follows the parity bit, so the frame is WIDTH+1 bits.
- Without the macro: no parity logic; the frame is WIDTH bits.

Decomposition:
- Shared package shift_pkg:
  - State enum typedef (IDLE, SHIFT, GAP).
  - Localparam helper for counter width.
  - Default WIDTH constant shared with the shift-chain blocks.
- Natural sub-module: shift_piso_core, the loadable shift register with load/shift/hold controls and LSB_FIRST select. The FSM and counter stay in shift_seq_ctrl.

Test Plan:
- Reset then in_data=4'b1011, in_valid=1 for one cycle (WIDTH=4, LSB_FIRST=1) -> sdo sequence 1,1,0,1 with sdo_en=1 on 4 consecutive cycles; done=1 on the 5th cycle; in_ready=0 for 4 cycles.
- LSB_FIRST=0, in_data=4'b1000 -> sdo sequence 1,0,0,0.
- hold=1 for 2 cycles after the 2nd bit of 4'b0110 -> sdo_en low for 2 cycles with sdo held at 1; total 6 cycles to done; bit order unchanged.
- Back-to-back: in_valid held high with words 4'hA then 4'h5, GAP_CYCLES=0 -> second accept at the cycle done=1 and 8 valid bits over 9 cycles. With GAP_CYCLES=3 -> 3 extra busy cycles with sdo_en=0 between words.
- Assert rst during the 3rd bit of 4'hF -> all outputs 0 immediately, in_ready=1, no done pulse; the next word transfers cleanly.
- With SHIFT_SEQ_PARITY_EN defined, in_data=4'b0111 -> bits 1,1,1,0 then parity 1; done follows the 5th bit.
